// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: carries main-decoder control bundles through the ID/EX,
// EX/MEM and MEM/WB control registers and generates load-use stall and
// taken-branch flush steering for the 5-stage RV32 core.
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   id_valid, id_ctrl       ID-stage instruction valid and control bundle
//                           {Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp[1:0]}
//   id_rs1, id_rs2, id_rd   ID-stage register indices
//   ex_zero                 ALU zero flag of the instruction in EX
//   ex_*                    EX-stage control (ALUSrc, ALUOp, rd)
//   mem_*                   MEM-stage control (MemRead, MemWrite, PCSrc)
//   wb_*                    WB-stage control (RegWrite, MemtoReg, rd)
//   PCWrite, IF_ID_Write    PC / IF-ID load enables (low during load-use stall)
//   IF_ID_Flush             IF/ID loads a NOP (taken branch)
//   stall_cnt, flush_cnt    saturating event counters, only with CTRL_PIPE_PERF_EN
//
// Optional feature macro: CTRL_PIPE_PERF_EN (adds CNT_W parameter and counters).

module ctrl_pipe_hazard #(
    parameter int unsigned REG_AW = 5
`ifdef CTRL_PIPE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [7:0]        id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              ex_ALUSrc,
    output logic [1:0]        ex_ALUOp,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_PCSrc,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [REG_AW-1:0] wb_rd,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // id_ctrl bit positions
    localparam int unsigned B_BRANCH   = 7;
    localparam int unsigned B_MEMREAD  = 6;
    localparam int unsigned B_MEMTOREG = 5;
    localparam int unsigned B_MEMWRITE = 4;
    localparam int unsigned B_ALUSRC   = 3;
    localparam int unsigned B_REGWRITE = 2;

    // ID/EX
    logic              ie_valid;
    logic [7:0]        ie_ctrl;
    logic [REG_AW-1:0] ie_rd;
    // EX/MEM
    logic              em_valid, em_branch, em_memread, em_memwrite;
    logic              em_memtoreg, em_regwrite, em_zero;
    logic [REG_AW-1:0] em_rd;
    // MEM/WB
    logic              mw_valid, mw_regwrite, mw_memtoreg;
    logic [REG_AW-1:0] mw_rd;

    logic              hazard;
    logic              pcsrc;
    logic [7:0]        id_ctrl_san;
    logic [REG_AW-1:0] id_rd_san;

    // Hazard detection, branch resolution and steering
    always_comb begin
        hazard      = 1'b0;
        pcsrc       = 1'b0;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;

        // rs2 is compared for every format; a spurious stall is harmless
        hazard = ie_valid & ie_ctrl[B_MEMREAD] & (ie_rd != '0) & id_valid &
                 ((ie_rd == id_rs1) | (ie_rd == id_rs2));
        pcsrc  = em_valid & em_branch & em_zero;

        // A flush squashes the stalled instruction, so it overrides the stall
        if (pcsrc) begin
            IF_ID_Flush = 1'b1;
        end else if (hazard) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end
    end

    // Decoder don't-cares are zeroed so they never reach the datapath
    always_comb begin
        id_ctrl_san             = id_ctrl;
        id_ctrl_san[B_MEMTOREG] = id_ctrl[B_MEMTOREG] & id_ctrl[B_REGWRITE];
        id_rd_san               = id_ctrl[B_REGWRITE] ? id_rd : '0;
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_valid    <= 1'b0;
            ie_ctrl     <= '0;
            ie_rd       <= '0;
            em_valid    <= 1'b0;
            em_branch   <= 1'b0;
            em_memread  <= 1'b0;
            em_memwrite <= 1'b0;
            em_memtoreg <= 1'b0;
            em_regwrite <= 1'b0;
            em_zero     <= 1'b0;
            em_rd       <= '0;
            mw_valid    <= 1'b0;
            mw_regwrite <= 1'b0;
            mw_memtoreg <= 1'b0;
            mw_rd       <= '0;
        end else begin
            if (!id_valid || hazard || pcsrc) begin
                ie_valid <= 1'b0;
                ie_ctrl  <= '0;
                ie_rd    <= '0;
            end else begin
                ie_valid <= 1'b1;
                ie_ctrl  <= id_ctrl_san;
                ie_rd    <= id_rd_san;
            end

            if (pcsrc) begin
                em_valid    <= 1'b0;
                em_branch   <= 1'b0;
                em_memread  <= 1'b0;
                em_memwrite <= 1'b0;
                em_memtoreg <= 1'b0;
                em_regwrite <= 1'b0;
                em_zero     <= 1'b0;
                em_rd       <= '0;
            end else begin
                em_valid    <= ie_valid;
                em_branch   <= ie_ctrl[B_BRANCH];
                em_memread  <= ie_ctrl[B_MEMREAD];
                em_memwrite <= ie_ctrl[B_MEMWRITE];
                em_memtoreg <= ie_ctrl[B_MEMTOREG];
                em_regwrite <= ie_ctrl[B_REGWRITE];
                em_zero     <= ex_zero;
                em_rd       <= ie_rd;
            end

            mw_valid    <= em_valid;
            mw_regwrite <= em_regwrite;
            mw_memtoreg <= em_memtoreg;
            mw_rd       <= em_rd;
        end
    end

    assign ex_ALUSrc    = ie_ctrl[B_ALUSRC];
    assign ex_ALUOp     = ie_ctrl[1:0];
    assign ex_rd        = ie_rd;
    assign mem_MemRead  = em_memread;
    assign mem_MemWrite = em_memwrite;
    assign mem_PCSrc    = pcsrc;
    assign wb_RegWrite  = mw_valid & mw_regwrite;
    assign wb_MemtoReg  = mw_memtoreg;
    assign wb_rd        = mw_rd;

`ifdef CTRL_PIPE_PERF_EN
    // Saturating stall / flush event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && !pcsrc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pcsrc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed testbench for ctrl_pipe_hazard.
module tb_ctrl_pipe_hazard;

    localparam logic [7:0] C_R    = 8'b00000110; // RegWrite, ALUOp=10
    localparam logic [7:0] C_LW   = 8'b01101100; // MemRead, MemtoReg, ALUSrc, RegWrite
    localparam logic [7:0] C_SW   = 8'b00011000; // MemWrite, ALUSrc
    localparam logic [7:0] C_SWX  = 8'b00111000; // store with MemtoReg don't-care = 1
    localparam logic [7:0] C_BEQ  = 8'b10000001; // Branch, ALUOp=01

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [7:0] id_ctrl;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero;
    logic       ex_ALUSrc;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rd;
    logic       mem_MemRead, mem_MemWrite, mem_PCSrc;
    logic       wb_RegWrite, wb_MemtoReg;
    logic [4:0] wb_rd;
    logic       PCWrite, IF_ID_Write, IF_ID_Flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef CTRL_PIPE_PERF_EN
    logic [1:0] stall_cnt, flush_cnt;
    ctrl_pipe_hazard #(.REG_AW(5), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_PCSrc(mem_PCSrc),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    ctrl_pipe_hazard #(.REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_PCSrc(mem_PCSrc),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush)
    );
`endif

    // Advance one rising edge, then settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        id_valid = v;
        id_ctrl  = c;
        id_rs1   = s1;
        id_rs2   = s2;
        id_rd    = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        ex_zero = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ex_zero = 1'b0;
        drive(1'b1, C_R, 5'd1, 5'd2, 5'd5);
        step();
        step();
        checks++; if (ex_ALUOp !== 2'b00) begin errors++; $display("FAIL rst_ex_ALUOp got %b want 00", ex_ALUOp); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL rst_ex_rd got %0d want 0", ex_rd); end
        checks++; if ({mem_MemRead, mem_MemWrite, mem_PCSrc, wb_RegWrite, wb_MemtoReg} !== 5'b0) begin
            errors++; $display("FAIL rst_stage_ctrl got %b want 00000",
                               {mem_MemRead, mem_MemWrite, mem_PCSrc, wb_RegWrite, wb_MemtoReg}); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd got %0d want 0", wb_rd); end
        checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush} !== 3'b110) begin
            errors++; $display("FAIL rst_steer got %b want 110", {PCWrite, IF_ID_Write, IF_ID_Flush}); end
        reset = 1'b0;
        step();
        checks++; if (ex_ALUOp !== 2'b10) begin errors++; $display("FAIL rst_release_ALUOp got %b want 10", ex_ALUOp); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL rst_release_rd got %0d want 5", ex_rd); end
        idle(4);
    endtask

    task automatic test_rtype();
        drive(1'b1, C_R, 5'd1, 5'd2, 5'd5);
        step();
        checks++; if (ex_ALUOp !== 2'b10) begin errors++; $display("FAIL r_ex_ALUOp got %b want 10", ex_ALUOp); end
        checks++; if (ex_ALUSrc !== 1'b0) begin errors++; $display("FAIL r_ex_ALUSrc got %b want 0", ex_ALUSrc); end
        drive(1'b1, C_SWX, 5'd3, 5'd4, 5'd9);
        step();
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL sw_ex_rd_sanitised got %0d want 0", ex_rd); end
        checks++; if (ex_ALUSrc !== 1'b1) begin errors++; $display("FAIL sw_ex_ALUSrc got %b want 1", ex_ALUSrc); end
        idle(0);
        step();
        checks++; if ({wb_RegWrite, wb_MemtoReg} !== 2'b10) begin
            errors++; $display("FAIL r_wb_ctrl got %b want 10", {wb_RegWrite, wb_MemtoReg}); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL r_wb_rd got %0d want 5", wb_rd); end
        checks++; if (mem_MemWrite !== 1'b1) begin errors++; $display("FAIL sw_mem_MemWrite got %b want 1", mem_MemWrite); end
        step();
        checks++; if ({wb_RegWrite, wb_MemtoReg, wb_rd} !== 7'b0) begin
            errors++; $display("FAIL sw_wb_sanitised got %b want 0000000", {wb_RegWrite, wb_MemtoReg, wb_rd}); end
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd7);
        step();
        drive(1'b1, C_R, 5'd7, 5'd2, 5'd8);
        #1;
        checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush} !== 3'b000) begin
            errors++; $display("FAIL lu_stall_steer got %b want 000", {PCWrite, IF_ID_Write, IF_ID_Flush}); end
        step();
        checks++; if ({PCWrite, IF_ID_Write} !== 2'b11) begin
            errors++; $display("FAIL lu_stall_one_cycle got %b want 11", {PCWrite, IF_ID_Write}); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble_ex_rd got %0d want 0", ex_rd); end
        checks++; if (mem_MemRead !== 1'b1) begin errors++; $display("FAIL lu_mem_MemRead got %b want 1", mem_MemRead); end
        step();
        checks++; if (ex_rd !== 5'd8) begin errors++; $display("FAIL lu_add_ex_rd got %0d want 8", ex_rd); end
        checks++; if ({wb_RegWrite, wb_MemtoReg, wb_rd} !== {2'b11, 5'd7}) begin
            errors++; $display("FAIL lu_lw_wb got %b want 1100111", {wb_RegWrite, wb_MemtoReg, wb_rd}); end
        idle(1);
        checks++; if (wb_RegWrite !== 1'b0) begin errors++; $display("FAIL lu_bubble_wb got %b want 0", wb_RegWrite); end
        step();
        checks++; if ({wb_RegWrite, wb_rd} !== {1'b1, 5'd8}) begin
            errors++; $display("FAIL lu_add_wb got %b want 101000", {wb_RegWrite, wb_rd}); end
        idle(3);
        // Load into x0 never stalls
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0);
        step();
        drive(1'b1, C_R, 5'd0, 5'd0, 5'd8);
        #1;
        checks++; if ({PCWrite, IF_ID_Write} !== 2'b11) begin
            errors++; $display("FAIL lu_x0_no_stall got %b want 11", {PCWrite, IF_ID_Write}); end
        step();
        checks++; if (ex_rd !== 5'd8) begin errors++; $display("FAIL lu_x0_ex_rd got %0d want 8", ex_rd); end
        idle(4);
    endtask

    task automatic test_branch();
        // Taken
        drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, C_SW, 5'd3, 5'd4, 5'd0);
        ex_zero = 1'b1;
        step();
        drive(1'b1, C_R, 5'd1, 5'd2, 5'd10);
        ex_zero = 1'b0;
        #1;
        checks++; if ({mem_PCSrc, IF_ID_Flush, PCWrite} !== 3'b111) begin
            errors++; $display("FAIL br_taken_steer got %b want 111", {mem_PCSrc, IF_ID_Flush, PCWrite}); end
        step();
        checks++; if ({mem_PCSrc, IF_ID_Flush} !== 2'b00) begin
            errors++; $display("FAIL br_flush_one_cycle got %b want 00", {mem_PCSrc, IF_ID_Flush}); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL br_squash_ex_rd got %0d want 0", ex_rd); end
        idle(0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_MemWrite, wb_RegWrite} !== 2'b00) begin
                errors++; $display("FAIL br_squash_%0d got %b want 00", i, {mem_MemWrite, wb_RegWrite}); end
            step();
        end
        idle(2);
        // Not taken
        drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, C_SW, 5'd3, 5'd4, 5'd0);
        step();
        drive(1'b1, C_R, 5'd1, 5'd2, 5'd10);
        #1;
        checks++; if ({mem_PCSrc, IF_ID_Flush} !== 2'b00) begin
            errors++; $display("FAIL br_nt_steer got %b want 00", {mem_PCSrc, IF_ID_Flush}); end
        step();
        checks++; if (mem_MemWrite !== 1'b1) begin errors++; $display("FAIL br_nt_sw got %b want 1", mem_MemWrite); end
        idle(2);
        checks++; if ({wb_RegWrite, wb_rd} !== {1'b1, 5'd10}) begin
            errors++; $display("FAIL br_nt_r_wb got %b want 101010", {wb_RegWrite, wb_rd}); end
        idle(3);
    endtask

    task automatic test_hazard_flush();
        drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd7);
        ex_zero = 1'b1;
        step();
        drive(1'b1, C_R, 5'd7, 5'd2, 5'd8);
        ex_zero = 1'b0;
        #1;
        checks++; if ({mem_PCSrc, PCWrite, IF_ID_Write, IF_ID_Flush} !== 4'b1111) begin
            errors++; $display("FAIL hf_steer got %b want 1111", {mem_PCSrc, PCWrite, IF_ID_Write, IF_ID_Flush}); end
        step();
        checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush} !== 3'b110) begin
            errors++; $display("FAIL hf_no_stall got %b want 110", {PCWrite, IF_ID_Write, IF_ID_Flush}); end
        checks++; if (mem_MemRead !== 1'b0) begin errors++; $display("FAIL hf_lw_squashed got %b want 0", mem_MemRead); end
        idle(3);
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd7);
        step();
        drive(1'b1, C_R, 5'd7, 5'd2, 5'd8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(0);
        #1;
        checks++; if ({PCWrite, IF_ID_Write, mem_MemRead, ex_rd} !== {3'b110, 5'd0}) begin
            errors++; $display("FAIL rst_mid_stall got %b want 11000000", {PCWrite, IF_ID_Write, mem_MemRead, ex_rd}); end
        idle(3);
    endtask

`ifdef CTRL_PIPE_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({stall_cnt, flush_cnt} !== 4'b0) begin
            errors++; $display("FAIL perf_reset got %b want 0000", {stall_cnt, flush_cnt}); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, C_LW, 5'd1, 5'd0, 5'd7);
            step();
            drive(1'b1, C_R, 5'd7, 5'd2, 5'd8);
            step();
            step();
            idle(2);
        end
        checks++; if (stall_cnt !== 2'd3) begin errors++; $display("FAIL perf_stall_sat got %0d want 3", stall_cnt); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0);
            step();
            drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
            ex_zero = 1'b1;
            step();
            idle(3);
        end
        checks++; if (flush_cnt !== 2'd2) begin errors++; $display("FAIL perf_flush got %0d want 2", flush_cnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({stall_cnt, flush_cnt} !== 4'b0) begin
            errors++; $display("FAIL perf_clear got %b want 0000", {stall_cnt, flush_cnt}); end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_branch();
        test_hazard_flush();
        test_reset_mid_stall();
`ifdef CTRL_PIPE_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
